// File: rtl/reg_read_sched_pkg.sv
// Shared types and sizes for the operand read scheduler.
package reg_read_sched_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned NUM_W     = 5;
    localparam int unsigned REG_IDX_W = 6;
    localparam int unsigned NREG      = 1 << REG_IDX_W;
    localparam int unsigned NSRC_DEF  = 3;
    localparam int unsigned NPORT_DEF = 2;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_READ = 2'd1,
        RS_DONE = 2'd2
    } rs_state_e;

    typedef struct packed {
        logic             gf;
        logic [NUM_W-1:0] num;
    } src_spec_t;

    // Flat {gf,num} index into the scoreboard.
    function automatic logic [REG_IDX_W-1:0] reg_idx(input src_spec_t s);
        return {s.gf, s.num};
    endfunction

endpackage

// File: rtl/reg_pick_n.sv
// Picks the first NPORT set bits of an eligibility vector, lowest index first.
module reg_pick_n #(
    parameter int unsigned NSRC  = 3,
    parameter int unsigned NPORT = 2,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NSRC-1:0]             elig,
    output logic [NPORT-1:0]            pick_vld,
    output logic [NPORT-1:0][IDX_W-1:0] pick_idx
);

    always_comb begin
        int unsigned rank;
        pick_vld = '0;
        pick_idx = '0;
        rank     = 0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (elig[i]) begin
                for (int unsigned p = 0; p < NPORT; p++) begin
                    if (rank == p) begin
                        pick_vld[p] = 1'b1;
                        pick_idx[p] = IDX_W'(i);
                    end
                end
                rank++;
            end
        end
    end

endmodule

// File: rtl/reg_read_sched.sv
// Issues operand reads for one instruction over a few register-file ports,
// waiting out scoreboard-busy registers, and hands the bundle to execute.
module reg_read_sched
    import reg_read_sched_pkg::*;
#(
    parameter int unsigned NSRC  = NSRC_DEF,
    parameter int unsigned NPORT = NPORT_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [NSRC-1:0]        req_mask,
    input  logic [NSRC-1:0]        req_gf,
    input  logic [NUM_W*NSRC-1:0]  req_num,
    output logic [NPORT-1:0]       rd_gfflag,
    output logic [NUM_W*NPORT-1:0] rd_num,
    input  logic [WIDTH*NPORT-1:0] rd_data,
    input  logic [NREG-1:0]        busy,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic [WIDTH*NSRC-1:0]  op_data
);

    localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    rs_state_e                      state_q, state_d;
    logic [NSRC-1:0]                pend_q, pend_d;
    src_spec_t [NSRC-1:0]           spec_q, spec_d;
    logic [NSRC-1:0][WIDTH-1:0]     buf_q, buf_d;
    logic [NSRC-1:0]                elig_c;
    logic [NPORT-1:0]               pick_vld;
    logic [NPORT-1:0][IDX_W-1:0]    pick_idx;
    logic                           accept_c;

    assign req_ready = (state_q == RS_IDLE) || ((state_q == RS_DONE) && op_ready);
    assign accept_c  = req_valid && req_ready;
    assign op_valid  = (state_q == RS_DONE);
    assign op_data   = buf_q;

    // A busy bit clearing this cycle makes its operand eligible this cycle.
    always_comb begin
        elig_c = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            elig_c[i] = (state_q == RS_READ) && pend_q[i] && !busy[reg_idx(spec_q[i])];
        end
    end

    reg_pick_n #(
        .NSRC  (NSRC),
        .NPORT (NPORT),
        .IDX_W (IDX_W)
    ) u_pick (
        .elig     (elig_c),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx)
    );

    always_comb begin
        rd_gfflag = '0;
        rd_num    = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (pick_vld[p]) begin
                rd_gfflag[p]                 = spec_q[pick_idx[p]].gf;
                rd_num[p*NUM_W +: NUM_W]     = spec_q[pick_idx[p]].num;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        spec_d  = spec_q;
        buf_d   = buf_q;
        case (state_q)
            RS_READ: begin
                for (int unsigned p = 0; p < NPORT; p++) begin
                    if (pick_vld[p]) begin
                        buf_d[pick_idx[p]]  = rd_data[p*WIDTH +: WIDTH];
                        pend_d[pick_idx[p]] = 1'b0;
                    end
                end
                if (pend_d == '0) begin
                    state_d = RS_DONE;
                end
            end
            RS_DONE: begin
                if (op_ready && !req_valid) begin
                    state_d = RS_IDLE;
                end
            end
            default: ;
        endcase
        // Accept (from IDLE or back-to-back from DONE) overrides the above.
        if (accept_c) begin
            pend_d = req_mask;
            buf_d  = '0;
            for (int unsigned i = 0; i < NSRC; i++) begin
                spec_d[i].gf  = req_gf[i];
                spec_d[i].num = req_num[i*NUM_W +: NUM_W];
            end
            state_d = (req_mask != '0) ? RS_READ : RS_DONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RS_IDLE;
            pend_q  <= '0;
            spec_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            spec_q  <= spec_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: doc/reg_read_sched.md
Name: reg_read_sched

Overview:
- Schedules operand reads for one instruction onto a small pool of combinational register-file read ports (reg_reader instances).
- Accepts a request of up to NSRC source specifiers, each a general/float flag plus a 5-bit number.
- Issues up to NPORT reads per cycle, skipping registers marked busy by the writeback scoreboard, and collects results into an operand buffer.
- Presents the operand bundle to the execute stage with a valid/ready handshake. Sits between decode and execute.

Parameters:
- NSRC, 3, maximum source operands per request.
- NPORT, 2, number of read ports driven (one reg_reader each).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  decode presents a request
- req_ready  out  1  scheduler accepts a request this cycle
- req_mask  in  NSRC  bit i = operand i required
- req_gf  in  NSRC  bit i: 0 general, 1 float
- req_num  in  5*NSRC  register number, operand i at [5i+4:5i]
- rd_gfflag  out  NPORT  per-port r_gfflag to reg_reader
- rd_num  out  5*NPORT  per-port r_num
- rd_data  in  `WIDTH*NPORT  per-port r_data (combinational, same cycle)
- busy  in  64  scoreboard; index {gf,num}, bit 1 = pending write
- op_valid  out  1  operand bundle complete
- op_ready  in  1  execute consumes bundle
- op_data  out  `WIDTH*NSRC  operand i at [`WIDTH*(i+1)-1:`WIDTH*i]

Behaviour:
- States: IDLE, READ, DONE. Reset: IDLE, pending=0, buffer=0, op_valid=0, req_ready=1, rd_gfflag=0, rd_num=0.
- req_ready = (state==IDLE) || (state==DONE && op_ready). Handshake completes on req_valid && req_ready at a rising edge.
- On accept, capture mask/gf/num and set pending=req_mask. Clear all buffer slots to 0.
- Next state on accept: READ if req_mask!=0, else DONE.
- READ, each cycle:
  - An operand is eligible when it is pending and busy[{gf_i,num_i}]==0.
  - Eligible operands are assigned in ascending index order to ports 0..NPORT-1. Eligible operands beyond NPORT wait for a later cycle.
  - Assigned ports drive rd_gfflag/rd_num combinationally from the captured spec. Unassigned ports drive 0/0.
  - At the edge, rd_data of each assigned port is written to its operand slot and that pending bit clears.
  - When pending becomes 0, go to DONE.
- Busy stall: while every pending operand is busy, stay in READ with no reads issued. There is no timeout.
  - A busy bit that clears in cycle t makes the operand eligible in cycle t, same cycle.
- DONE: op_valid=1 and op_data stable until op_ready.
  - On op_ready without a new request, go to IDLE.
  - On op_ready with req_valid (back-to-back), capture the new request and go to READ or DONE. op_valid drops for at least one cycle if the new mask is nonzero.
- Latency, no busy operands: op_valid asserted ceil(popcount(mask)/NPORT)+1 cycles after the accept edge. Mask 0 gives 1 cycle.
- Duplicate specifiers (same gf/num in two slots) are read independently; each consumes a port.
- Masked-off slots read as 0.
- Reset asserted mid-operation: immediate return to reset values. The captured request is discarded.

Decomposition:
- Shared in common.h: existing `WIDTH and `NUM. Add `REG_IDX_W (6, {gf,num} index width) and state encodings `RS_IDLE/`RS_READ/`RS_DONE (2 bits).
- One natural sub-module, reg_pick_n: combinational picker taking an NSRC eligible vector. It returns per port a valid bit and the operand index of the k-th lowest set bit.
- Top-level instantiates NPORT reg_reader copies outside this block. The bench instantiates them against a model register file.

Test Plan:
- Three operands, nothing busy, req {g3,f7,g31}: accept at T0. Cycle T1 ports read g3, f7; T2 port0 reads g31. op_valid at T3 with op_data = {R[g31],R[f7],R[g3]}.
- Mask=3'b000: op_valid one cycle after accept, op_data=0, no port activity (rd_num=0).
- Operand f7 busy for 4 cycles, other operands free: g3 and g31 read in T1 while f7 waits. f7 is read in the cycle its busy bit clears; op_valid the next cycle.
- op_ready held low 5 cycles in DONE: op_data/op_valid stable and req_ready=0. Then op_ready=1 with req_valid=1 accepts the next request in that same cycle.
- Duplicate req {g5,g5,g5} with NPORT=2: two reads in T1, one in T2, all three slots equal R[g5].
- rstn pulsed low during READ with one operand outstanding: outputs return to reset values asynchronously. After release the block is IDLE and req_ready=1, and no stale op_valid appears.
